// File: rtl/pair_xor_accum.sv
// Streaming pair-difference/XOR accumulator: per-beat f and parity are folded
// across a packet and reported once per packet with its saturating beat count.
module pair_xor_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_f,
  output logic             out_par,
  output logic [CNT_W-1:0] out_beats
);

  localparam int PAIRS = WIDTH / 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAIRS-1:0] pair_x;
  logic             beat_f;
  logic             beat_p;

  logic             s1_valid;
  logic             s1_last;
  logic             s1_f;
  logic             s1_p;
  logic             s1_adv;
  logic             accept;

  logic             acc_f;
  logic             acc_p;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    pair_x = '0;
    for (int i = 0; i < PAIRS; i++) begin
      pair_x[i] = in_data[2*i] ^ in_data[2*i+1];
    end
  end

  assign beat_f = in_data[0] ^ (&pair_x);
  assign beat_p = ^in_data;

  // A last beat may only leave S1 when the result register is free or retiring.
  assign s1_adv   = s1_valid & (~s1_last | ~out_valid | out_ready);
  assign in_ready = ~s1_valid | s1_adv;
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_f     <= 1'b0;
      s1_p     <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_last  <= in_last;
      s1_f     <= beat_f;
      s1_p     <= beat_p;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_f     <= 1'b0;
      acc_p     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_f     <= 1'b0;
      out_par   <= 1'b0;
      out_beats <= '0;
    end else begin
      if (s1_adv && s1_last) begin
        out_f     <= acc_f ^ s1_f;
        out_par   <= acc_p ^ s1_p;
        out_beats <= cnt_inc;
        out_valid <= 1'b1;
        acc_f     <= 1'b0;
        acc_p     <= 1'b0;
        cnt       <= '0;
      end else begin
        if (s1_adv) begin
          acc_f <= acc_f ^ s1_f;
          acc_p <= acc_p ^ s1_p;
          cnt   <= cnt_inc;
        end
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pair_xor_accum.sv
// Bench for pair_xor_accum: three configurations share one stimulus stream and
// are checked against a packet-level model plus literal expectations.
module tb_pair_xor_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic       rdy_a, rdy_b, rdy_c;
  logic       ov_a, ov_b, ov_c;
  logic       f_a, f_b, f_c;
  logic       p_a, p_b, p_c;
  logic [7:0] b_a, b_b;
  logic [1:0] b_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pair_xor_accum #(.WIDTH(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data[3:0]), .in_last(in_last), .out_valid(ov_a),
    .out_ready(out_ready), .out_f(f_a), .out_par(p_a), .out_beats(b_a));

  pair_xor_accum #(.WIDTH(16), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .in_last(in_last), .out_valid(ov_b),
    .out_ready(out_ready), .out_f(f_b), .out_par(p_b), .out_beats(b_b));

  pair_xor_accum #(.WIDTH(16), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
    .in_data(in_data), .in_last(in_last), .out_valid(ov_c),
    .out_ready(out_ready), .out_f(f_c), .out_par(p_c), .out_beats(b_c));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  typedef struct {
    logic f;
    logic p;
    int   beats;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  res_t q2[$];
  int   wid[3]  = '{4, 16, 16};
  int   cmax[3] = '{255, 255, 3};
  logic pf[3];
  logic pp[3];
  int   pcnt[3];
  logic hold[3];
  int   last_f[3];
  int   last_p[3];
  int   last_b[3];

  function automatic logic m_f(input logic [15:0] d, input int w);
    logic all_diff = 1'b1;
    for (int i = 0; i < w / 2; i++) if (d[2*i] == d[2*i+1]) all_diff = 1'b0;
    return d[0] ^ all_diff;
  endfunction

  function automatic logic m_p(input logic [15:0] d, input int w);
    logic p = 1'b0;
    for (int i = 0; i < w; i++) p = p ^ d[i];
    return p;
  endfunction

  task automatic push(input int k, input res_t r);
    case (k)
      0: q0.push_back(r);
      1: q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask

  task automatic check_out(input int k, input logic ov, input logic f,
                           input logic p, input int beats);
    res_t e;
    int   n;
    n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (hold[k]) begin
      chk($sformatf("hold_valid[%0d]", k), ov, 1);
      chk($sformatf("hold_data[%0d]", k), {f, p, beats},
          {last_f[k][0], last_p[k][0], last_b[k]});
    end
    if (ov) begin
      if (n == 0) begin
        chk($sformatf("unexpected_out_valid[%0d]", k), 1, 0);
      end else begin
        e = (k == 0) ? q0[0] : (k == 1) ? q1[0] : q2[0];
        chk($sformatf("out_f[%0d]", k), f, e.f);
        chk($sformatf("out_par[%0d]", k), p, e.p);
        chk($sformatf("out_beats[%0d]", k), beats, e.beats);
        if (out_ready) begin
          case (k)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
          endcase
        end
      end
    end
    hold[k]   = ov & ~out_ready;
    last_f[k] = int'(f);
    last_p[k] = int'(p);
    last_b[k] = beats;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
      for (int k = 0; k < 3; k++) begin
        pf[k] = 1'b0; pp[k] = 1'b0; pcnt[k] = 0; hold[k] = 1'b0;
      end
    end else begin
      check_out(0, ov_a, f_a, p_a, int'(b_a));
      check_out(1, ov_b, f_b, p_b, int'(b_b));
      check_out(2, ov_c, f_c, p_c, int'(b_c));
      if (in_valid && rdy_b) begin
        for (int k = 0; k < 3; k++) begin
          res_t r;
          pf[k]   = pf[k] ^ m_f(in_data, wid[k]);
          pp[k]   = pp[k] ^ m_p(in_data, wid[k]);
          pcnt[k] = pcnt[k] + 1;
          if (in_last) begin
            r.f = pf[k];
            r.p = pp[k];
            r.beats = (pcnt[k] > cmax[k]) ? cmax[k] : pcnt[k];
            push(k, r);
            pf[k] = 1'b0; pp[k] = 1'b0; pcnt[k] = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] d, input logic last, output int stalls);
    stalls = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!rdy_b && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!rdy_b) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_ov(input int k);
    int n = 0;
    @(negedge clk);
    while (((k == 0) ? !ov_a : (k == 1) ? !ov_b : !ov_c) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk($sformatf("wait_ov_timeout[%0d]", k), 0, 1);
  endtask

  task automatic drain;
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q0.size() + q1.size() + q2.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int s;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {ov_a, ov_b, ov_c}, 0);
    chk("reset_out_f_par", {f_a, p_a, f_b, p_b, f_c, p_c}, 0);
    chk("reset_out_beats", {b_a, b_b, b_c}, 0);
    chk("reset_in_ready", rdy_b, 1);

    // 1) single beat 0110 on the 4-bit instance, latency t+2, one cycle wide
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h0006; in_last = 1'b1;
    @(negedge clk);
    chk("t1_ready", rdy_b, 1);
    chk("t1_ov_t", ov_a, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("t1_ov_t1", ov_a, 0);
    @(negedge clk);
    chk("t1_ov_t2", ov_a, 1);
    chk("t1_f", f_a, 1);
    chk("t1_par", p_a, 0);
    chk("t1_beats", b_a, 1);
    @(negedge clk);
    chk("t1_ov_t3", ov_a, 0);
    @(posedge clk); #1;

    // 2) 0110, 1001, 0011(last): per-beat f = 1,0,1 and p = 0,0,0
    send(16'h0006, 1'b0, s);
    send(16'h0009, 1'b0, s);
    send(16'h0003, 1'b1, s);
    wait_ov(0);
    chk("t2_f", f_a, 0);
    chk("t2_par", p_a, 0);
    chk("t2_beats", b_a, 3);
    drain();

    // 3) result held while out_ready=0; non-last beats flow, last beat stalls
    out_ready = 1'b0;
    send(16'h00F0, 1'b1, s);
    wait_ov(1);
    @(posedge clk); #1;
    send(16'h0002, 1'b0, s);
    chk("t3_nonlast_stall", s, 0);
    send(16'h0004, 1'b0, s);
    chk("t3_nonlast_stall2", s, 0);
    send(16'h0008, 1'b1, s);
    in_valid = 1'b1; in_data = 16'h0101; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stalled_ready", rdy_b, 0);
      chk("t3_pending_valid", ov_b, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_ready", rdy_b, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    drain();

    // 4) back-to-back single-beat packets at full rate
    send(16'h0001, 1'b1, s);
    chk("t4_ready0", s, 0);
    send(16'h0003, 1'b1, s);
    chk("t4_ready1", s, 0);
    wait_ov(1);
    chk("t4_first", {f_b, p_b}, 2'b11);
    @(negedge clk);
    chk("t4_second_valid", ov_b, 1);
    chk("t4_second", {f_b, p_b}, 2'b10);
    drain();

    // 5) reset mid-packet drops it; the next 1-beat packet stands alone
    send(16'h1234, 1'b0, s);
    send(16'h5678, 1'b0, s);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_output", {ov_a, ov_b, ov_c}, 0);
    end
    @(posedge clk); #1;
    send(16'hFFFF, 1'b1, s);
    wait_ov(1);
    chk("t5_beats", b_b, 1);
    chk("t5_par", p_b, 0);
    chk("t5_f", f_b, 1);
    drain();

    // 6) six beats of 0001: 2-bit counter saturates at 3
    for (int i = 0; i < 6; i++) send(16'h0001, (i == 5), s);
    wait_ov(2);
    chk("t6_beats_sat", b_c, 3);
    chk("t6_par", p_c, 0);
    chk("t6_f", f_c, 0);
    chk("t6_beats_wide", b_b, 6);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
